// File: rtl/mode_seq.sv
// Two-level run sequencer: a control FSM runs 1..pas_q passes, each pass a counter sweep 0..lim_q.
// Latency: start cycle to done cycle is (L+5)+(P-1)(L+2); done/aborted are registered pulses.
// No backpressure: start is a request honoured only in IDLE, abort cancels any active run.
module mode_seq #(
  parameter int CNT_W  = 4,
  parameter int PASS_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  cnt,
  output logic [PASS_W-1:0] pass_idx
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_LAST = 2'd2
  } ctrl_t;

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } cstate_t;

  ctrl_t              ctrl_q, ctrl_d;
  cstate_t            cst_q, cst_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [PASS_W-1:0]  pas_q, pas_d;
  logic [PASS_W-1:0]  pidx_q, pidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enter_q;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic               exit_w;
  logic               take_abort;
  logic [PASS_W:0]    pidx_inc;

  // Counter has reached the latched limit; limit 0 exits on the first S1 cycle.
  assign exit_w     = (cst_q == S1) && (cnt_q >= lim_q);
  // Abort only matters while a run is active; in IDLE it merely blocks start.
  assign take_abort = abort && (ctrl_q != C_IDLE);
  // One extra bit so pass_idx+1 never wraps when compared with pas_q.
  assign pidx_inc   = {1'b0, pidx_q} + (PASS_W+1)'(1);

  // Control FSM next-state: accept start, advance passes, finish through LAST.
  always_comb begin
    ctrl_d    = ctrl_q;
    lim_d     = lim_q;
    pas_d     = pas_q;
    pidx_d    = pidx_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (ctrl_q)
      C_IDLE: begin
        if (start && !abort) begin
          ctrl_d = C_RUN;
          lim_d  = limit;
          pas_d  = (passes == '0) ? PASS_W'(1) : passes;
          pidx_d = '0;
        end
      end
      C_RUN: begin
        if (exit_w) begin
          if (pidx_inc < {1'b0, pas_q}) begin
            pidx_d = pidx_inc[PASS_W-1:0];
          end else begin
            ctrl_d = C_LAST;
          end
        end
      end
      C_LAST: begin
        ctrl_d = C_IDLE;
        done_d = 1'b1;
      end
      default: begin
        ctrl_d = C_IDLE;
      end
    endcase
    // Abort wins over exit and over LAST->IDLE, so no done is produced.
    if (take_abort) begin
      ctrl_d    = C_IDLE;
      pidx_d    = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= C_IDLE;
      lim_q     <= '0;
      pas_q     <= PASS_W'(1);
      pidx_q    <= '0;
      enter_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      lim_q     <= lim_d;
      pas_q     <= pas_d;
      pidx_q    <= pidx_d;
      enter_q   <= (ctrl_q == C_RUN);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Counter FSM next-state: arm from S0 when control is running, sweep in S1.
  always_comb begin
    cst_d = cst_q;
    cnt_d = cnt_q;
    case (cst_q)
      S0: begin
        cnt_d = '0;
        if (enter_q && (ctrl_q == C_RUN)) begin
          cst_d = S1;
        end
      end
      S1: begin
        if (exit_w) begin
          cst_d = S0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cst_d = S0;
        cnt_d = '0;
      end
    endcase
    if (take_abort) begin
      cst_d = S0;
      cnt_d = '0;
    end
  end

  // Counter state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cst_q <= S0;
      cnt_q <= '0;
    end else begin
      cst_q <= cst_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy     = (ctrl_q != C_IDLE);
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign cnt      = cnt_q;
  assign pass_idx = pidx_q;

endmodule
